multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Sequencer FSM for the multi-cycle RV32I datapath variant, which shares one unified instruction/data memory and one ALU across several cycles per instruction. Drives every mux select and write enable of that datapath from the opcode and funct fields held in the instruction register, plus the ALU Zero flag. A memory-ready handshake stretches the fetch and memory-access states for wait-stated memories. Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
USE_MEM_READY, 1, when 0 the MemReady input is ignored and treated as constant 1.

Ports:
CLK  input  1  clock, rising edge.
rst  input  1  reset. Asynchronous and active-high.
op  input  7  Instr[6:0] from the instruction register.
funct3  input  3  Instr[14:12].
funct7b5  input  1  Instr[30].
Zero  input  1  ALU zero flag.
MemReady  input  1  memory access completes this cycle.
PCWrite  output  1  PC register enable.
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
MemWrite  output  1  memory write enable.
IRWrite  output  1  instruction/OldPC register enable.
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
ALUSrcB  output  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
RegWrite  output  1  register file write enable.
InstrDone  output  1  one-cycle pulse in the final cycle of each retired instruction.
IllegalInstr  output  1  pulse in DECODE when the opcode is unsupported.

Behaviour:
- State register is the only storage; all outputs are decoded combinationally from state and inputs (Moore, except PCWrite and handshake gating).
- rst high: state = FETCH asynchronously. PCWrite, MemWrite, IRWrite, RegWrite, InstrDone and IllegalInstr are forced to 0 while rst is high. Select outputs take their FETCH values.
- Per-state outputs; anything unlisted is 0 / 00:
  - FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10. IRWrite and PCUpdate are asserted only when the handshake is ready (rdy).
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00. This computes the branch target.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1. MemWrite stays asserted and stable until rdy.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
- PCWrite = PCUpdate | (Branch & Zero).
- rdy = MemReady | ~USE_MEM_READY.
- Transitions:
  - FETCH -> DECODE if rdy, else stay in FETCH.
  - DECODE branches on op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> FETCH, with IllegalInstr = 1 and InstrDone = 1; the instruction is treated as a NOP.
  - MEMADR -> MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD -> MEMWB if rdy, else stay.
  - MEMWRITE -> FETCH if rdy, else stay.
  - EXECUTER / EXECUTEI -> ALUWB.
  - MEMWB, ALUWB, JAL, BEQ -> FETCH.
  - Unreachable state encodings -> FETCH.
- InstrDone is 1 in MEMWB, ALUWB, JAL and BEQ, and in MEMWRITE when rdy is 1.
- ALU decode:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10 decodes on funct3:
    - 000: sub if op[5] & funct7b5, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - any other funct3: add.
- ImmSrc is decoded from op in every state:
  - lw and I-type -> 00.
  - sw -> 01.
  - beq -> 10.
  - jal -> 11.
  - any other op -> 00.
- Cycle counts with MemReady held high: lw 5, sw 4, R/I-type 4, jal 3, beq 3.
- Reset asserted mid-instruction aborts it. No write enable is asserted after rst rises. Execution resumes at FETCH on the first edge after rst falls.

Decomposition:
- Shared package multicycle_pkg holds:
  - state encodings;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ);
  - ALUControl codes;
  - ResultSrc, ALUSrcA and ALUSrcB select codes.
- One sub-module, alu_decoder (ALUOp, funct3, op5, funct7b5 -> ALUControl), is reusable by the single-cycle control.

Test Plan:
- Reset: rst = 1 mid-MEMWRITE -> MemWrite = 0 immediately. After rst falls, the first cycle is FETCH with IRWrite = 1 and PCWrite = 1 (MemReady = 1).
- lw, op = 0000011, MemReady = 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. RegWrite = 1 and ResultSrc = 01 only in cycle 5, with InstrDone = 1.
- sub, op = 0110011, funct3 = 000, funct7b5 = 1 -> ALUControl = 001 in EXECUTER, ALUWB the next cycle, 4 cycles total.
- beq with Zero = 1 in BEQ -> PCWrite = 1 and ALUControl = 001. Repeat with Zero = 0 -> PCWrite = 0. Both take 3 cycles.
- sw with MemReady low for 3 cycles in MEMWRITE -> MemWrite held at 1 for 4 cycles, InstrDone only on the ready cycle. Repeat with MemReady low during FETCH -> IRWrite = 0 and PCWrite = 0 until ready.
- op = 1111111 -> in DECODE, IllegalInstr = 1 and InstrDone = 1, next state FETCH, no RegWrite or MemWrite asserted.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALU operation codes and the datapath mux select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from ALUOp and the funct fields; purely combinational, no handshake.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // funct7b5 only selects sub for R-type; for addi it is an immediate bit
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: 3-5 cycles per instruction, Moore outputs from the state register.
// FETCH, MEMREAD and MEMWRITE hold until MemReady; write enables are forced low while rst is high.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       IllegalInstr
);

  state_t     state;
  state_t     next_state;
  logic       rdy;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;

  assign rdy = MemReady | ~USE_MEM_READY;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ResultSrc  = RES_ALURESULT;
        ALUSrcB    = SRCB_FOUR;
        ir_write   = rdy;
        pc_update  = rdy;
        next_state = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here from OldPC + ImmExt
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTER;
          OP_I:         next_state = S_EXECUTEI;
          OP_JAL:       next_state = S_JAL;
          OP_BEQ:       next_state = S_BEQ;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        instr_done = rdy;
        next_state = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNC;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNC;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  // Gate enables with rst so nothing is written in the cycle reset arrives
  assign PCWrite      = ~rst & (pc_update | (branch & Zero));
  assign MemWrite     = ~rst & mem_write;
  assign IRWrite      = ~rst & ir_write;
  assign RegWrite     = ~rst & reg_write;
  assign InstrDone    = ~rst & instr_done;
  assign IllegalInstr = ~rst & illegal;

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors checked against hand-written values.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.USE_MEM_READY(1'b1)) dut (
    .CLK(CLK), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .InstrDone(InstrDone),
    .IllegalInstr(IllegalInstr)
  );

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, InstrDone, IllegalInstr};

  // Packs hand-written expected fields in the same order as obs
  function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] ac, input logic [1:0] imm,
                                     input logic rw, input logic dn, input logic il);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, dn, il};
  endfunction

  task automatic test_reset();
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #1;
      checks++;
      if (obs !== pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0)) begin
        errors++; $display("FAIL reset_hold cycle %0d got %h want %h", i, obs,
                           pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0));
      end
    end
    @(posedge CLK); #1;
    rst = 1'b0; #1;
    checks++;
    if (obs !== pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0)) begin
      errors++; $display("FAIL reset_release got %h want %h", obs,
                         pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0));
    end
  endtask

  task automatic test_lw();
    logic [17:0] exp [5];
    exp = '{pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0),
            pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0,0),
            pk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0),
            pk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0),
            pk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,1,0)};
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL lw cycle %0d got %h want %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [2:0] f3 [6] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b000, 3'b100};
    logic       f7 [6] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
    logic [2:0] ac [6] = '{3'b001, 3'b101, 3'b011, 3'b010, 3'b000, 3'b000};
    logic [17:0] exp [4];
    for (int k = 0; k < 6; k++) begin
      exp = '{pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0),
              pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0,0),
              pk(0,0,0,0,2'b00,2'b10,2'b00,ac[k],2'b00,0,0,0),
              pk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0)};
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        op = 7'b0110011; funct3 = f3[k]; funct7b5 = f7[k]; Zero = 1'b0; MemReady = 1'b1;
        #1;
        checks++;
        if (obs !== exp[i]) begin
          errors++; $display("FAIL rtype %0d cycle %0d got %h want %h", k, i, obs, exp[i]);
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [2:0] f3 [3] = '{3'b110, 3'b000, 3'b010};
    logic       f7 [3] = '{1'b0,   1'b1,   1'b0};
    logic [2:0] ac [3] = '{3'b011, 3'b000, 3'b101};
    logic [17:0] exp [4];
    for (int k = 0; k < 3; k++) begin
      exp = '{pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0),
              pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0,0),
              pk(0,0,0,0,2'b00,2'b10,2'b01,ac[k],2'b00,0,0,0),
              pk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0)};
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        op = 7'b0010011; funct3 = f3[k]; funct7b5 = f7[k]; Zero = 1'b0; MemReady = 1'b1;
        #1;
        checks++;
        if (obs !== exp[i]) begin
          errors++; $display("FAIL itype %0d cycle %0d got %h want %h", k, i, obs, exp[i]);
        end
      end
    end
  endtask

  task automatic test_beq();
    logic [17:0] exp [3];
    for (int z = 1; z >= 0; z--) begin
      exp = '{pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b10,0,0,0),
              pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0,0,0),
              pk(z[0],0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,1,0)};
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = z[0]; MemReady = 1'b1;
        #1;
        checks++;
        if (obs !== exp[i]) begin
          errors++; $display("FAIL beq zero=%0d cycle %0d got %h want %h", z, i, obs, exp[i]);
        end
      end
    end
  endtask

  task automatic test_jal();
    logic [17:0] exp [3];
    exp = '{pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b11,0,0,0),
            pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0,0,0),
            pk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,1,0)};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL jal cycle %0d got %h want %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_sw_wait();
    logic        mr  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [17:0] exp [7];
    exp = '{pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0),
            pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0,0),
            pk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0),
            pk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0),
            pk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0),
            pk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0),
            pk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,1,0)};
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; MemReady = mr[i];
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL sw_wait cycle %0d got %h want %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_fetch_stall();
    logic        mr  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [17:0] exp [6];
    exp = '{pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0),
            pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0),
            pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0),
            pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0,0),
            pk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0),
            pk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,1,0)};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; MemReady = mr[i];
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL fetch_stall cycle %0d got %h want %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [17:0] exp [2];
    exp = '{pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0),
            pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,1,1)};
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1; MemReady = 1'b1;
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL illegal cycle %0d got %h want %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_memwrite();
    logic        mr  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [17:0] exp [4];
    exp = '{pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0),
            pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0,0),
            pk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0),
            pk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; MemReady = mr[i];
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL rst_mid pre cycle %0d got %h want %h", i, obs, exp[i]);
      end
    end
    rst = 1'b1; #1;
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++; $display("FAIL rst_mid memwrite got %b want 0", MemWrite);
    end
    checks++;
    if (obs !== pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0)) begin
      errors++; $display("FAIL rst_mid vector got %h want %h", obs,
                         pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0));
    end
    @(negedge CLK); MemReady = 1'b1; #1;
    checks++;
    if (obs !== pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0)) begin
      errors++; $display("FAIL rst_mid held got %h want %h", obs,
                         pk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0));
    end
    @(negedge CLK); rst = 1'b0; #1;
    checks++;
    if (obs !== pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0)) begin
      errors++; $display("FAIL rst_mid resume_fetch got %h want %h", obs,
                         pk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0,0));
    end
    @(negedge CLK); #1;
    checks++;
    if (obs !== pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0,0)) begin
      errors++; $display("FAIL rst_mid resume_decode got %h want %h", obs,
                         pk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0,0));
    end
  endtask

  initial begin
    rst = 1'b1;
    op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    test_reset();
    test_lw();
    test_rtype();
    test_itype();
    test_beq();
    test_jal();
    test_sw_wait();
    test_fetch_stall();
    test_illegal();
    test_reset_mid_memwrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
